// File: rtl/reg_bank_arbiter_pkg.sv
// Shared register-map definitions: default bank geometry and the fabric FSM encoding.
package reg_bank_arbiter_pkg;

   localparam int DEFAULT_NUM_REGISTERS = 32;
   localparam int DEFAULT_DATA_WIDTH    = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_HOLD = 2'd2
   } fab_state_t;

endpackage

// File: rtl/reg_bank_storage.sv
// Register array with an SPI write port (RO-gated, wins on collision), a fabric
// write port, and two asynchronous read ports returning 0 outside the bank.
module reg_bank_storage
   import reg_bank_arbiter_pkg::*;
#(
   parameter int NUM_REGISTERS = DEFAULT_NUM_REGISTERS,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = $clog2(NUM_REGISTERS),
   parameter logic [NUM_REGISTERS-1:0] RO_MASK = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     spi_we,
   input  logic [ADDRESS_WIDTH-1:0] spi_addr,
   input  logic [DATA_WIDTH-1:0]    spi_wdata,
   input  logic                     fab_we,
   input  logic [ADDRESS_WIDTH-1:0] fab_addr,
   input  logic [DATA_WIDTH-1:0]    fab_wdata,
   output logic [DATA_WIDTH-1:0]    spi_rdata,
   output logic [DATA_WIDTH-1:0]    fab_rdata,
   output logic                     spi_commit
);

   logic [DATA_WIDTH-1:0] bank [NUM_REGISTERS];
   logic spi_in_range;
   logic fab_in_range;
   logic fab_commit;

   assign spi_in_range = 32'(spi_addr) < NUM_REGISTERS;
   assign fab_in_range = 32'(fab_addr) < NUM_REGISTERS;
   assign spi_commit   = spi_we && spi_in_range && !RO_MASK[spi_addr];
   assign fab_commit   = fab_we && fab_in_range;

   // The SPI write is issued last so it owns the register if both ever coincide.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGISTERS; i++) begin
            bank[i] <= '0;
         end
      end else begin
         if (fab_commit) begin
            bank[fab_addr] <= fab_wdata;
         end
         if (spi_commit) begin
            bank[spi_addr] <= spi_wdata;
         end
      end
   end

   assign spi_rdata = spi_in_range ? bank[spi_addr] : '0;
   assign fab_rdata = fab_in_range ? bank[fab_addr] : '0;

endmodule

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by an SPI slave (absolute priority) and a fabric
// request/acknowledge port, with per-register SPI change flags.
module reg_bank_arbiter
   import reg_bank_arbiter_pkg::*;
#(
   parameter int NUM_REGISTERS = DEFAULT_NUM_REGISTERS,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = $clog2(NUM_REGISTERS),
   parameter logic [NUM_REGISTERS-1:0] RO_MASK = '0
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [ADDRESS_WIDTH-1:0] SPI_ADDRESS,
   input  logic [DATA_WIDTH-1:0]    SPI_WRITE_DATA,
   input  logic                     SPI_WREN,
   output logic [DATA_WIDTH-1:0]    SPI_READ_DATA,
   input  logic                     F_REQ,
   input  logic                     F_WE,
   input  logic [ADDRESS_WIDTH-1:0] F_ADDR,
   input  logic [DATA_WIDTH-1:0]    F_WDATA,
   output logic                     F_ACK,
   output logic [DATA_WIDTH-1:0]    F_RDATA,
   output logic [NUM_REGISTERS-1:0] CHANGED,
   input  logic [NUM_REGISTERS-1:0] CHANGED_CLR,
   output fab_state_t               dbg_state
);

   fab_state_t state;
   logic ack_q;
   logic accept;
   logic spi_commit;
   logic [DATA_WIDTH-1:0] fab_rdata;
   logic [NUM_REGISTERS-1:0] set_vec;

   // Fabric handshake: F_REQ is the valid and holds F_WE/F_ADDR/F_WDATA stable
   // until F_ACK; a request is taken in IDLE on any cycle without SPI_WREN, and
   // F_ACK is high for the single ACK cycle that follows acceptance.
   assign accept = (state == ST_IDLE) && F_REQ && !SPI_WREN;

   reg_bank_storage #(
      .NUM_REGISTERS (NUM_REGISTERS),
      .DATA_WIDTH    (DATA_WIDTH),
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .RO_MASK       (RO_MASK)
   ) u_storage (
      .clk        (CLK),
      .reset      (RESET),
      .spi_we     (SPI_WREN),
      .spi_addr   (SPI_ADDRESS),
      .spi_wdata  (SPI_WRITE_DATA),
      .fab_we     (accept & F_WE),
      .fab_addr   (F_ADDR),
      .fab_wdata  (F_WDATA),
      .spi_rdata  (SPI_READ_DATA),
      .fab_rdata  (fab_rdata),
      .spi_commit (spi_commit)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= ST_IDLE;
         ack_q   <= 1'b0;
         F_RDATA <= '0;
      end else begin
         ack_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state   <= ST_ACK;
                  ack_q   <= 1'b1;
                  F_RDATA <= fab_rdata;
               end
            end
            ST_ACK:  state <= ST_HOLD;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // A reset landing in the ACK cycle drops the transfer, so the pulse is masked.
   assign F_ACK     = ack_q & ~RESET;
   assign dbg_state = state;

   always_comb begin
      set_vec = '0;
      for (int i = 0; i < NUM_REGISTERS; i++) begin
         if (spi_commit && (32'(SPI_ADDRESS) == i)) begin
            set_vec[i] = 1'b1;
         end
      end
   end

   // Set beats clear when both hit the same bit in one cycle.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         CHANGED <= '0;
      end else begin
         CHANGED <= (CHANGED & ~CHANGED_CLR) | set_vec;
      end
   end

endmodule

// File: doc/reg_bank_arbiter.md
REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 Parameter NUM_REGISTERS, default 32: number of registers in the bank.
REQ-002 Parameter DATA_WIDTH, default 8: register width.
REQ-003 Parameter ADDRESS_WIDTH, default $clog2(NUM_REGISTERS): address width of both ports.
REQ-004 Parameter RO_MASK, default 0 (NUM_REGISTERS bits): bit i set means register i is read-only from SPI.
REQ-005 Port CLK  input  1: single clock; all state updates on its rising edge.
REQ-006 Port RESET  input  1: reset, synchronous and active-high.
REQ-007 Port SPI_ADDRESS  input  ADDRESS_WIDTH: SPI slave register address.
REQ-008 Port SPI_WRITE_DATA  input  DATA_WIDTH: SPI slave write data.
REQ-009 Port SPI_WREN  input  1: SPI write strobe, one CLK cycle per byte.
REQ-010 Port SPI_READ_DATA  output  DATA_WIDTH: combinational read of bank[SPI_ADDRESS].
REQ-011 Port F_REQ  input  1: fabric access request, held until F_ACK.
REQ-012 Port F_WE  input  1: fabric request is a write (1) or read (0).
REQ-013 Port F_ADDR  input  ADDRESS_WIDTH: fabric address.
REQ-014 Port F_WDATA  input  DATA_WIDTH: fabric write data.
REQ-015 Port F_ACK  output  1: one-cycle pulse, access complete.
REQ-016 Port F_RDATA  output  DATA_WIDTH: registered read data, valid while F_ACK=1, held afterwards.
REQ-017 Port CHANGED  output  NUM_REGISTERS: bit i set when SPI has written register i.
REQ-018 Port CHANGED_CLR  input  NUM_REGISTERS: per-bit clear strobe for CHANGED.

Function
REQ-019 SPI port SHALL have absolute priority: an SPI_WREN cycle SHALL write bank[SPI_ADDRESS] at that edge unless RO_MASK[SPI_ADDRESS]=1.
REQ-020 Fabric FSM SHALL have states IDLE, ACK, HOLD.
REQ-021 IDLE: F_REQ=1 and SPI_WREN=0 -> access performed at the edge, go ACK; F_REQ=1 and SPI_WREN=1 -> stay IDLE (stall).
REQ-022 ACK: F_ACK=1 for exactly this cycle; F_RDATA = bank[F_ADDR] sampled at acceptance edge (pre-write value for writes); go HOLD.
REQ-023 HOLD: no acceptance this cycle; go IDLE; peak fabric throughput one access per 3 cycles.
REQ-024 Fabric writes SHALL ignore RO_MASK and SHALL NOT set CHANGED.
REQ-025 Fabric read accepted in the cycle after an SPI write to the same address SHALL return the new value.
REQ-026 SPI_READ_DATA SHALL reflect a fabric or SPI write in the cycle following the write edge.
REQ-027 CHANGED[i] SHALL set on an accepted (non-RO) SPI write to i; clear on CHANGED_CLR[i]; set wins when simultaneous.
REQ-028 Addresses >= NUM_REGISTERS: writes ignored, reads return 0, fabric still receives F_ACK.
REQ-029 Maximum fabric wait from F_REQ to acceptance SHALL be one cycle per SPI_WREN pulse; no starvation logic beyond this.

Reset
REQ-030 On RESET=1 at an edge: all registers 0, CHANGED 0, FSM IDLE, F_ACK 0, F_RDATA 0.
REQ-031 RESET SHALL override a same-cycle SPI_WREN or fabric acceptance; a request pending or in ACK/HOLD SHALL be dropped with no F_ACK.

Structure
REQ-032 FSM state encoding and default NUM_REGISTERS/DATA_WIDTH constants SHALL live in the shared register-map header/package.
REQ-033 Storage (array, write mux, RO_MASK gating, async read) SHALL be sub-module reg_bank_storage; FSM and CHANGED logic in reg_bank_arbiter.

Verification
REQ-034 After reset, SPI_ADDRESS=5 -> SPI_READ_DATA=8'h00; CHANGED=0.
REQ-035 SPI_WREN, addr 3, data 8'hFA -> next cycle SPI_READ_DATA(addr 3)=8'hFA, CHANGED[3]=1; CHANGED_CLR[3] pulse -> CHANGED[3]=0.
REQ-036 F_REQ write addr 7 data 8'h5C with no SPI traffic -> F_ACK one cycle later; then fabric read addr 7 -> F_RDATA=8'h5C.
REQ-037 F_REQ read addr 2 in same cycle as SPI_WREN addr 2 data 8'h11 -> one-cycle stall, F_ACK two cycles after F_REQ, F_RDATA=8'h11.
REQ-038 RO_MASK bit 4 set: SPI write 8'hAA to addr 4 -> value unchanged, CHANGED[4]=0; fabric write 8'h33 -> reads 8'h33.
REQ-039 RESET asserted during ACK state of a fabric write -> no F_ACK, all registers read 8'h00 after reset.
